seed_sched: RTL
===============

# seed_sched

Two-requester scheduler and sequencer for the shared 16-bit seed adder (`sum = nseed + pseed`). Each requester submits a job of (initial seed, step, iteration count). The block grants the adder round-robin, closes the `pseed` feedback through a register, and iterates `acc <= acc + step` for `count` cycles. It returns the final seed on a valid/ready result port tagged with the requester id. It sits between the seed consumers (PRNG/test-pattern users) and the adder datapath.

## Interface
- `WIDTH`, 16: seed/step/result width.
- `CNT_W`, 8: iteration-count width.

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has a job
- `req0_ready`  out  1  requester 0 job accepted this cycle
- `req0_seed`  in  WIDTH  initial seed, requester 0
- `req0_step`  in  WIDTH  step added each iteration, requester 0
- `req0_count`  in  CNT_W  number of additions, requester 0
- `req1_valid`, `req1_ready`, `req1_seed`, `req1_step`, `req1_count`: same as requester 0, for requester 1
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res_data`  out  WIDTH  final seed
- `res_id`  out  1  requester that owns the result
- `busy`  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, arbitration**
  - If any `reqN_valid` is high, the arbiter grants one requester. The previously granted requester has lower priority. After reset, requester 0 has priority.
  - `reqN_ready` is high only for the granted requester, only in IDLE. It is driven combinationally from the valids.
- **IDLE, on handshake**
  - Register: `acc <= seed`, `step_r <= step`, `rem <= count`, `id <= grant`; update the round-robin pointer.
  - If `count == 0`, go to DONE. Otherwise go to RUN.
- **RUN**
  - Each cycle: `acc <= acc + step_r` modulo 2^WIDTH (carry discarded), `rem <= rem - 1`.
  - When `rem == 1`, perform that final add and go to DONE.
- **DONE**
  - `res_valid = 1`, `res_data = acc`, `res_id = id`, all held stable until `res_ready`.
  - On `res_valid && res_ready`, go to IDLE.
  - No new job is accepted until the state is IDLE. There is no bypass from DONE straight to accept.
- A requester dropping `valid` before its grant is legal; the job is simply not taken. Job fields are sampled only on the handshake cycle.
- Values are unsigned. Results wrap, e.g. 0xFFF0 + 0x0020 = 0x0010.
- `rem` is not checked for underflow, because RUN is only entered with `count ≥ 1`.

## Timing
- Reset values:
  - state IDLE; `acc`, `step_r`, `rem` = 0
  - `res_valid` 0, `res_data` 0, `res_id` 0, `busy` 0
  - `req0_ready` and `req1_ready` are 0 while `rst` is high
  - round-robin pointer set so requester 0 wins first
- Latency: handshake at edge T gives `res_valid` high after edge T+`count`+1, i.e. T+1 for `count` 0 and T+5 for `count` 4.
- Throughput: one job per `count` + 2 cycles with `res_ready` tied high.
- Simultaneous valids: exactly one `ready` is asserted. The loser keeps `valid` and is served next.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial result is lost and no `res_valid` is produced.
- `res_ready` high while `res_valid` is low is ignored.

## Structure
- Package `seed_pkg` holds:
  - state enum `seed_state_t` {IDLE, RUN, DONE}
  - default `WIDTH`/`CNT_W` constants
  - requester id constants `REQ0 = 1'b0`, `REQ1 = 1'b1`
- Sub-module `seed_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `en`, `update`.
  - Outputs: one-hot `gnt[1:0]`.
  - Holds the pointer register; async reset.
- The adder and accumulator register stay inline in `seed_sched`.

## Test plan
- **Basic job.** req0 seed 0x0001, step 0x0003, count 4; `res_ready` high → `res_data` 0x000D, `res_id` 0, `res_valid` 5 cycles after accept.
- **Wrap-around.** req1 seed 0xFFF0, step 0x0020, count 1 → `res_data` 0x0010, `res_id` 1.
- **Zero count.** req0 seed 0xBEEF, step 0x1234, count 0 → `res_data` 0xBEEF one cycle after accept.
- **Contention.** Both valid right after reset with counts 2 → req0 served first, then req1. A second simultaneous pair → req0 first again (req1 was last granted). No cycle ever has both readys high.
- **Backpressure.** `res_ready` low for 3 cycles in DONE → `res_data`/`res_id` stable, `req*_ready` held 0, then IDLE one cycle after the handshake.
- **Reset mid-run.** Assert `rst` 2 cycles into a count-10 job → all outputs at reset values at once. After release, a new req1 job completes correctly with no stale `res_valid`.

Source files
------------

// File: rtl/seed_pkg.sv
// Shared types and constants for the seed adder scheduler.
package seed_pkg;
    localparam int SEED_WIDTH = 16;
    localparam int SEED_CNT_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seed_state_t;
endpackage

// File: rtl/seed_rr_arb.sv
// 2-way round-robin arbiter; combinational one-hot grant, pointer updated on accept.
module seed_rr_arb
    import seed_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       update,
    output logic [1:0] gnt
);
    // Requester that currently holds priority.
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (ptr == REQ0) begin
                if (req[0])      gnt = 2'b01;
                else if (req[1]) gnt = 2'b10;
            end else begin
                if (req[1])      gnt = 2'b10;
                else if (req[0]) gnt = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= REQ0;
        end else if (update && (gnt != 2'b00)) begin
            // The winner drops to lower priority.
            ptr <= gnt[0] ? REQ1 : REQ0;
        end
    end
endmodule

// File: rtl/seed_sched.sv
// Two-requester scheduler for the shared seed adder: accepts a job, iterates acc += step
// count times, and returns the result on a valid/ready port tagged with the requester id.
module seed_sched
    import seed_pkg::*;
#(
    parameter int WIDTH = SEED_WIDTH,
    parameter int CNT_W = SEED_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_seed,
    input  logic [WIDTH-1:0] req0_step,
    input  logic [CNT_W-1:0] req0_count,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_seed,
    input  logic [WIDTH-1:0] req1_step,
    input  logic [CNT_W-1:0] req1_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);
    seed_state_t      state, state_nx;
    logic [WIDTH-1:0] acc, step_r, sum;
    logic [CNT_W-1:0] rem;
    logic             id;
    logic [1:0]       gnt;
    logic             take;
    logic [WIDTH-1:0] sel_seed, sel_step;
    logic [CNT_W-1:0] sel_count;

    seed_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .en     (state == IDLE),
        .update (take),
        .gnt    (gnt)
    );

    assign take       = |gnt;
    // Grants are combinational, so mask them while reset holds the block.
    assign req0_ready = gnt[0] & ~rst;
    assign req1_ready = gnt[1] & ~rst;

    assign sel_seed  = gnt[1] ? req1_seed  : req0_seed;
    assign sel_step  = gnt[1] ? req1_step  : req0_step;
    assign sel_count = gnt[1] ? req1_count : req0_count;

    // Feedback adder: pseed closes through acc, carry discarded.
    assign sum = acc + step_r;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (take) state_nx = (sel_count == '0) ? DONE : RUN;
            RUN:  if (rem == CNT_W'(1)) state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            step_r <= '0;
            rem    <= '0;
            id     <= REQ0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (take) begin
                    acc    <= sel_seed;
                    step_r <= sel_step;
                    rem    <= sel_count;
                    id     <= gnt[1] ? REQ1 : REQ0;
                end
                RUN: begin
                    acc <= sum;
                    rem <= rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign res_data  = acc;
    assign res_id    = id;
    assign busy      = (state != IDLE);
endmodule
